vfpu_job_sequencer: RTL and testbench

Sequences vector jobs onto the single-issue, non-stallable vfpu pipeline. It pairs elements from operand streams A and B and issues at most one pair per cycle. A credit scheme ensures every in-flight result has a slot in a local result FIFO, because the vfpu has no back-pressure. It holds the operation code constant for the whole job, since the vfpu uses it combinationally in several pipeline stages. It sits between the streamer/engine and the vfpu instance.

---
 rtl/vfpu_job_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_vfpu_job_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfpu_job_sequencer.sv
// vfpu_job_sequencer
// Feeds paired A/B stream elements into the single-issue, non-stallable vfpu pipeline and
// collects its results in a small first-word-fall-through FIFO. Since the vfpu cannot be
// stalled, a credit scheme only issues a pair when the FIFO is guaranteed to have room for
// the result. The operation code is latched at job start and held until done.
//
// Ports:
//   clk_i, rst_ni                        clock, asynchronous active-low reset
//   start_i, len_i, op_i                 job request; len/op sampled with start_i in IDLE
//   busy_o, done_o, flags_o              job status; done_o is a one-cycle pulse,
//                                        flags_o is the sticky OR of vfpu flags for the job
//   a_data_i, a_valid_i, a_ready_o       operand stream A
//   b_data_i, b_valid_i, b_ready_o       operand stream B (consumed together with A)
//   r_data_o, r_valid_o, r_ready_i       result stream
//   vfpu_opa_o, vfpu_opb_o, vfpu_op_o,   issue side of the vfpu
//   vfpu_valid_o
//   vfpu_result_i, vfpu_flags_i,         completion side of the vfpu
//   vfpu_done_i
module vfpu_job_sequencer #(
    parameter int unsigned FP_WIDTH   = 32,
    parameter int unsigned OP_WIDTH   = 2,
    parameter int unsigned FLAG_WIDTH = 5,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic [OP_WIDTH-1:0]   op_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [FLAG_WIDTH-1:0] flags_o,
    input  logic [FP_WIDTH-1:0]   a_data_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [FP_WIDTH-1:0]   b_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [FP_WIDTH-1:0]   r_data_o,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [FP_WIDTH-1:0]   vfpu_opa_o,
    output logic [FP_WIDTH-1:0]   vfpu_opb_o,
    output logic [OP_WIDTH-1:0]   vfpu_op_o,
    output logic                  vfpu_valid_o,
    input  logic [FP_WIDTH-1:0]   vfpu_result_i,
    input  logic [FLAG_WIDTH-1:0] vfpu_flags_i,
    input  logic                  vfpu_done_i
);

    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;
    localparam int unsigned SUM_WIDTH = CNT_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} seqState_t;

    seqState_t             stateQ;
    logic [LEN_WIDTH-1:0]  lenQ, issuedQ, retiredQ;
    logic [OP_WIDTH-1:0]   opQ;
    logic [FLAG_WIDTH-1:0] flagsQ;
    logic                  doneQ;
    logic [CNT_WIDTH-1:0]  inflightQ, fifoCountQ;
    logic [PTR_WIDTH-1:0]  wrPtrQ, rdPtrQ;
    logic [FP_WIDTH-1:0]   memQ [FIFO_DEPTH];

    logic                 creditOk, issue, resultIn, pop, fifoEmpty, fifoFull;
    logic [SUM_WIDTH-1:0] occupancy;

    // Every pair in flight or parked in the FIFO owns one FIFO slot.
    assign occupancy = {1'b0, inflightQ} + {1'b0, fifoCountQ};
    assign creditOk  = occupancy < SUM_WIDTH'(FIFO_DEPTH);
    assign issue     = (stateQ == StRun) & a_valid_i & b_valid_i & creditOk;
    // A completion with nothing outstanding is spurious and dropped.
    assign resultIn  = vfpu_done_i & (inflightQ != '0);
    assign fifoEmpty = (fifoCountQ == '0);
    assign fifoFull  = (fifoCountQ == CNT_WIDTH'(FIFO_DEPTH));
    assign pop       = ~fifoEmpty & r_ready_i;

    assign busy_o       = (stateQ != StIdle);
    assign done_o       = doneQ;
    assign flags_o      = flagsQ;
    assign vfpu_op_o    = opQ;
    assign a_ready_o    = issue;
    assign b_ready_o    = issue;
    assign vfpu_valid_o = issue;
    assign vfpu_opa_o   = issue ? a_data_i : '0;
    assign vfpu_opb_o   = issue ? b_data_i : '0;
    assign r_valid_o    = ~fifoEmpty;
    assign r_data_o     = fifoEmpty ? '0 : memQ[rdPtrQ];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stateQ    <= StIdle;
            lenQ      <= '0;
            issuedQ   <= '0;
            retiredQ  <= '0;
            opQ       <= '0;
            flagsQ    <= '0;
            doneQ     <= 1'b0;
            inflightQ <= '0;
        end else begin
            doneQ <= 1'b0;
            if (issue && !resultIn) begin
                inflightQ <= inflightQ + CNT_WIDTH'(1);
            end else if (!issue && resultIn) begin
                inflightQ <= inflightQ - CNT_WIDTH'(1);
            end
            if (resultIn) begin
                flagsQ <= flagsQ | vfpu_flags_i;
            end
            case (stateQ)
                StIdle: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            lenQ     <= len_i;
                            opQ      <= op_i;
                            flagsQ   <= '0;
                            issuedQ  <= '0;
                            retiredQ <= '0;
                            stateQ   <= StRun;
                        end else begin
                            doneQ <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (issue) begin
                        issuedQ <= issuedQ + LEN_WIDTH'(1);
                        if ((issuedQ + LEN_WIDTH'(1)) == lenQ) begin
                            stateQ <= StDrain;
                        end
                    end
                    if (pop) begin
                        retiredQ <= retiredQ + LEN_WIDTH'(1);
                    end
                end
                StDrain: begin
                    if (pop) begin
                        retiredQ <= retiredQ + LEN_WIDTH'(1);
                        if ((retiredQ + LEN_WIDTH'(1)) == lenQ) begin
                            doneQ  <= 1'b1;
                            stateQ <= StIdle;
                        end
                    end
                end
                default: stateQ <= StIdle;
            endcase
        end
    end

    // Result FIFO: pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtrQ     <= '0;
            rdPtrQ     <= '0;
            fifoCountQ <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                memQ[i] <= '0;
            end
        end else begin
            if (resultIn) begin
                memQ[wrPtrQ] <= vfpu_result_i;
                wrPtrQ       <= wrPtrQ + PTR_WIDTH'(1);
            end
            if (pop) begin
                rdPtrQ <= rdPtrQ + PTR_WIDTH'(1);
            end
            if (resultIn && !pop) begin
                fifoCountQ <= fifoCountQ + CNT_WIDTH'(1);
            end else if (!resultIn && pop) begin
                fifoCountQ <= fifoCountQ - CNT_WIDTH'(1);
            end
        end
    end

`ifndef SYNTHESIS
    // Credit accounting must make an overflowing push impossible.
    assert property (@(posedge clk_i) disable iff (!rst_ni) !(resultIn && fifoFull && !pop));
`endif

endmodule

// File: tb/tb_vfpu_job_sequencer.sv
// Testbench for vfpu_job_sequencer: a fixed-latency vfpu stand-in computes single-precision
// results (truncating) via real arithmetic; expected results are queued when a job's
// operands are prepared and a monitor pops/compares on every result handshake.
module tb_vfpu_job_sequencer;

    localparam int unsigned FP_WIDTH   = 32;
    localparam int unsigned OP_WIDTH   = 2;
    localparam int unsigned FLAG_WIDTH = 5;
    localparam int unsigned LEN_WIDTH  = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam logic [1:0]  OpAdd      = 2'd0;
    localparam logic [1:0]  OpSub      = 2'd1;
    localparam logic [1:0]  OpMul      = 2'd2;
    localparam logic [4:0]  FlagOf     = 5'b00100;

    logic                  clk_i = 1'b0;
    logic                  rst_ni;
    logic                  start_i;
    logic [LEN_WIDTH-1:0]  len_i;
    logic [OP_WIDTH-1:0]   op_i;
    logic                  busy_o, done_o;
    logic [FLAG_WIDTH-1:0] flags_o;
    logic [FP_WIDTH-1:0]   a_data_i, b_data_i, r_data_o;
    logic                  a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic                  r_valid_o, r_ready_i;
    logic [FP_WIDTH-1:0]   vfpu_opa_o, vfpu_opb_o, vfpu_result_i;
    logic [OP_WIDTH-1:0]   vfpu_op_o;
    logic                  vfpu_valid_o, vfpu_done_i;
    logic [FLAG_WIDTH-1:0] vfpu_flags_i;

    vfpu_job_sequencer #(
        .FP_WIDTH  (FP_WIDTH),
        .OP_WIDTH  (OP_WIDTH),
        .FLAG_WIDTH(FLAG_WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .len_i        (len_i),
        .op_i         (op_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .flags_o      (flags_o),
        .a_data_i     (a_data_i),
        .a_valid_i    (a_valid_i),
        .a_ready_o    (a_ready_o),
        .b_data_i     (b_data_i),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .r_data_o     (r_data_o),
        .r_valid_o    (r_valid_o),
        .r_ready_i    (r_ready_i),
        .vfpu_opa_o   (vfpu_opa_o),
        .vfpu_opb_o   (vfpu_opb_o),
        .vfpu_op_o    (vfpu_op_o),
        .vfpu_valid_o (vfpu_valid_o),
        .vfpu_result_i(vfpu_result_i),
        .vfpu_flags_i (vfpu_flags_i),
        .vfpu_done_i  (vfpu_done_i)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- single-precision helpers (normals only, truncation) ----------------
    function automatic real toReal(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Returns {flags, result}.
    function automatic logic [36:0] fromReal(input real r);
        logic [63:0] d;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {5'd0, d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        if (e >= 255) return {FlagOf, d[63], 8'hFF, 23'd0};
        if (e <= 0) return {5'd0, d[63], 31'd0};
        return {5'd0, d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [36:0] fpOp(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        real x, y, z;
        x = toReal(a);
        y = toReal(b);
        case (op)
            OpAdd:   z = x + y;
            OpSub:   z = x - y;
            default: z = x * y;
        endcase
        return fromReal(z);
    endfunction

    function automatic logic [31:0] randFp();
        logic [31:0] v;
        v        = $urandom;
        v[30:23] = 8'($urandom_range(120, 134));
        return v;
    endfunction

    // ---------------- vfpu stand-in: 3-stage, in order, shares reset ----------------
    logic [2:0]  pipeV;
    logic [31:0] pipeR [3];
    logic [4:0]  pipeF [3];
    logic [36:0] stubOut;

    assign stubOut = fpOp(vfpu_op_o, vfpu_opa_o, vfpu_opb_o);

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipeV <= '0;
            for (int i = 0; i < 3; i++) begin
                pipeR[i] <= '0;
                pipeF[i] <= '0;
            end
        end else begin
            pipeV    <= {pipeV[1:0], vfpu_valid_o};
            pipeR[0] <= stubOut[31:0];
            pipeF[0] <= stubOut[36:32];
            pipeR[1] <= pipeR[0];
            pipeF[1] <= pipeF[0];
            pipeR[2] <= pipeR[1];
            pipeF[2] <= pipeF[1];
        end
    end

    assign vfpu_done_i   = pipeV[2];
    assign vfpu_result_i = pipeR[2];
    assign vfpu_flags_i  = pipeF[2];

    // ---------------- shared bench state ----------------
    int          checks = 0;
    int          errors = 0;
    int          cycle = 0;
    logic [31:0] aQ[$], bQ[$], expQ[$], stimA[$], stimB[$];
    int          aGap = 0, bGap = 0, rMode = 0;
    int          accCnt = 0, retCnt = 0, doneCnt = 0, vfpuValidCnt = 0;
    int          lastRHsCycle = 0, lastDoneCycle = 0;
    logic        doneBusy = 1'b0;
    logic [1:0]  jobOp = OpAdd;
    int          n, a0, d0;

    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    // Stream driver: updates inputs 1 time unit after each edge, samples handshakes mid-cycle.
    initial begin
        logic        aHs, bHs;
        logic [31:0] tmp;
        aHs = 1'b0;
        bHs = 1'b0;
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        a_data_i  = '0;
        b_data_i  = '0;
        r_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (aHs && aQ.size() > 0) tmp = aQ.pop_front();
            if (bHs && bQ.size() > 0) tmp = bQ.pop_front();
            a_valid_i = (aQ.size() > 0) && (aGap == 0 || $urandom_range(0, 1) == 1);
            b_valid_i = (bQ.size() > 0) && (bGap == 0 || $urandom_range(0, 1) == 1);
            a_data_i  = (aQ.size() > 0) ? aQ[0] : '0;
            b_data_i  = (bQ.size() > 0) ? bQ[0] : '0;
            r_ready_i = (rMode == 0) ? 1'b1 : (rMode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            aHs = a_valid_i && a_ready_o;
            bHs = b_valid_i && b_ready_o;
        end
    end

    // Monitor: scoreboard pops on result handshakes, plus issue-side invariants.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (a_ready_o || b_ready_o) begin
                    check("pairing", {a_ready_o, b_ready_o, a_valid_i, b_valid_i}, 4'hF);
                    check("credit", ((accCnt - retCnt) < int'(FIFO_DEPTH)), 1);
                    accCnt++;
                end
                if (vfpu_valid_o) begin
                    vfpuValidCnt++;
                    check("op hold", vfpu_op_o, jobOp);
                end
                if (r_valid_o && r_ready_i) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL result: unexpected %h, none expected", r_data_o);
                    end else begin
                        check("result", r_data_o, expQ.pop_front());
                    end
                    retCnt++;
                    lastRHsCycle = cycle;
                end
                if (done_o) begin
                    doneCnt++;
                    lastDoneCycle = cycle;
                    doneBusy      = busy_o;
                end
            end
        end
    end

    task automatic fillRandom(input int len);
        stimA.delete();
        stimB.delete();
        for (int k = 0; k < len; k++) begin
            stimA.push_back(randFp());
            stimB.push_back(randFp());
        end
    endtask

    task automatic runJob(input int len, input logic [1:0] op, input int hold, input bit midStart);
        logic [36:0] o;
        logic [4:0]  expF;
        int          jd0, jv0, ja0, w;
        expF = '0;
        for (int k = 0; k < len; k++) begin
            o = fpOp(op, stimA[k], stimB[k]);
            expQ.push_back(o[31:0]);
            expF |= o[36:32];
        end
        aQ    = stimA;
        bQ    = stimB;
        jd0   = doneCnt;
        jv0   = vfpuValidCnt;
        ja0   = accCnt;
        jobOp = op;
        if (hold > 0) rMode = 1;
        start_i = 1'b1;
        len_i   = LEN_WIDTH'(len);
        op_i    = op;
        tick();
        start_i = 1'b0;
        len_i   = 16'($urandom);
        op_i    = 2'($urandom_range(0, 2));
        check("start busy", busy_o, 1);
        check("start flags", flags_o, 0);
        if (hold > 0) begin
            repeat (hold) tick();
            check("credit stall", accCnt - ja0, FIFO_DEPTH);
            check("stall ready", a_ready_o, 0);
            rMode = 0;
        end
        if (midStart) begin
            tick();
            start_i = 1'b1;
            len_i   = 16'd3;
            op_i    = OpSub;
            tick();
            start_i = 1'b0;
        end
        w = 0;
        while (doneCnt == jd0 && w < 2000) begin
            tick();
            w++;
        end
        check("done pulse", doneCnt - jd0, 1);
        check("busy at done", doneBusy, 0);
        check("done latency", lastDoneCycle - lastRHsCycle, 1);
        check("results left", expQ.size(), 0);
        check("issue count", vfpuValidCnt - jv0, len);
        check("flags", flags_o, expF);
        tick();
        tick();
        check("single done", doneCnt - jd0, 1);
        expQ.delete();
        aQ.delete();
        bQ.delete();
    endtask

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        len_i   = '0;
        op_i    = '0;
        repeat (3) @(posedge clk_i);
        #3;
        check("reset ctrl", {busy_o, done_o, flags_o, a_ready_o, b_ready_o, r_valid_o,
                             vfpu_valid_o, vfpu_op_o}, '0);
        check("reset data", r_data_o | vfpu_opa_o | vfpu_opb_o, '0);
        rst_ni = 1'b1;
        tick();
        tick();

        // Directed ADD: 1+1, 2+1, 3+1, 4+1.
        stimA = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        stimB = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
        runJob(4, OpAdd, 0, 1'b0);

        // MUL with results back-pressured: only FIFO_DEPTH pairs may enter.
        fillRandom(8);
        runJob(8, OpMul, 20, 1'b0);

        // B stream gaps and random result back-pressure.
        bGap  = 1;
        rMode = 2;
        fillRandom(10);
        runJob(10, OpSub, 0, 1'b0);
        bGap  = 0;
        rMode = 0;

        // Zero-length job.
        d0      = doneCnt;
        a0      = vfpuValidCnt;
        start_i = 1'b1;
        len_i   = '0;
        op_i    = OpMul;
        tick();
        start_i = 1'b0;
        check("zero-len done", done_o, 1);
        check("zero-len busy", busy_o, 0);
        tick();
        check("zero-len pulse", done_o, 0);
        check("zero-len count", doneCnt - d0, 1);
        check("zero-len issue", vfpuValidCnt - a0, 0);

        // ADD job with an attempted SUB start mid-job and A gaps.
        aGap = 1;
        fillRandom(6);
        runJob(6, OpAdd, 0, 1'b1);
        aGap = 0;

        // Overflow flag is sticky after done.
        stimA = {32'h7F000000};
        stimB = {32'h7F000000};
        runJob(1, OpMul, 0, 1'b0);
        check("overflow sticky", flags_o[2], 1);

        // Reset with two pairs in flight.
        fillRandom(2);
        aQ      = stimA;
        bQ      = stimB;
        rMode   = 1;
        jobOp   = OpAdd;
        a0      = accCnt;
        d0      = doneCnt;
        start_i = 1'b1;
        len_i   = 16'd6;
        op_i    = OpAdd;
        tick();
        start_i = 1'b0;
        check("restart flags clear", flags_o, 0);
        n = 0;
        while ((accCnt - a0) < 2 && n < 50) begin
            tick();
            n++;
        end
        check("two issued", accCnt - a0, 2);
        rst_ni = 1'b0;
        #1;
        check("abort ctrl", {busy_o, done_o, flags_o, a_ready_o, b_ready_o, r_valid_o,
                             vfpu_valid_o, vfpu_op_o}, '0);
        check("abort data", r_data_o | vfpu_opa_o | vfpu_opb_o, '0);
        repeat (2) tick();
        aQ.delete();
        bQ.delete();
        expQ.delete();
        accCnt = 0;
        retCnt = 0;
        rMode  = 0;
        rst_ni = 1'b1;
        repeat (3) tick();
        check("no done on abort", doneCnt - d0, 0);

        // A fresh job after the abort.
        fillRandom(2);
        runJob(2, OpAdd, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
